rx_frame_deserializer: RTL and testbench
========================================

// Module: rx_frame_deserializer
// PURPOSE
//  Parametrised UART receive deserializer with frame sequencing and checking. Sits after the
//  data sampler: takes one majority-sampled bit per bit-period strobe, assembles 5..DATA_WIDTH
//  data bits LSB- or MSB-first, checks optional even/odd parity and 1 or 2 stop bits, and
//  presents a registered parallel word with a one-cycle valid pulse or an error pulse.
// PARAMETERS
//  DATA_WIDTH  8                          max data bits per frame (>=5); width of P_DATA
//  LEN_W       $clog2(DATA_WIDTH+1)       width of data_len
// PORTS
//  rx_frame_deserializer_clk  in   1           single clock, all logic on rising edge
//  rx_frame_deserializer_rst  in   1           synchronous, active-high reset
//  deser_en       in   1           frame enable; low aborts any frame in progress
//  start_det      in   1           1-cycle pulse: start bit confirmed, data bit 0 follows
//  sample_strobe  in   1           1-cycle pulse at each bit's sample point
//  sampled_bit    in   1           sampled line value, valid when sample_strobe=1
//  data_len       in   LEN_W       data bits per frame; captured at frame start
//  par_en         in   1           1 = parity bit present; captured at frame start
//  par_type       in   1           0 = even, 1 = odd; captured at frame start
//  msb_first      in   1           1 = first data bit is MSB; captured at frame start
//  two_stop       in   1           1 = two stop bits; captured at frame start
//  P_DATA         out  DATA_WIDTH  last good word, right-aligned, unused MSBs zero
//  data_valid     out  1           1-cycle pulse: new P_DATA, frame error-free
//  par_err        out  1           1-cycle pulse: parity mismatch
//  stp_err        out  1           1-cycle pulse: any stop bit sampled 0
//  busy           out  1           high while FSM not IDLE
// BEHAVIOUR
//  - Reset (sync, high): FSM=IDLE; P_DATA, data_valid, par_err, stp_err, busy, counters,
//    shift reg = 0. Reset mid-frame discards the frame, no pulses.
//  - FSM: IDLE -> DATA -> [PARITY if par_en] -> STOP1 -> [STOP2 if two_stop] -> IDLE.
//  - IDLE: start_det & deser_en -> DATA next cycle; capture config, clear bit counter, shift
//    reg, running parity. data_len < 5 -> 5; data_len > DATA_WIDTH -> DATA_WIDTH.
//  - Strobe in IDLE ignored, including same cycle as start_det. start_det outside IDLE ignored.
//  - DATA: per strobe, store sampled_bit, bit_cnt++, parity ^= bit.
//    LSB-first: k-th received bit (k=0..len-1) -> P_DATA[k].
//    MSB-first: k-th received bit -> P_DATA[len-1-k]. Bits [DATA_WIDTH-1:len] always 0.
//    Strobe with bit_cnt = len-1 leaves DATA.
//  - PARITY: on strobe, expected = parity ^ par_type; mismatch sets frame par flag.
//  - STOP1/STOP2: on strobe, sampled_bit=0 sets frame stop flag.
//    Errors reported only at frame end, never mid-frame.
//  - Frame end = strobe in last stop state. Next cycle: FSM=IDLE, busy=0.
//    Same cycle, registered outputs:
//    no errors -> P_DATA updated, data_valid=1.
//    any error -> par_err/stp_err per flag, data_valid=0, P_DATA holds previous good word.
//    Latency: last-stop strobe -> outputs 1 cycle.
//  - start_det accepted from the first IDLE cycle after frame end (back-to-back frames).
//  - deser_en=0 in any non-IDLE state -> IDLE next cycle, no pulses, P_DATA held.
//  - busy = 1 from the cycle after accepted start_det until the cycle after frame end.
//  - All pulse outputs are high exactly one cycle; never both data_valid and an error.
// TESTING
//  1. len=8, LSB-first, no parity, 1 stop, bits 1,0,1,0,0,1,0,1 then 1 -> P_DATA=0xA5,
//     data_valid for 1 cycle, 1 cycle after stop strobe.
//  2. Same bits, msb_first=1 -> P_DATA=0xA5 bit-reversed = 0xA5 from mirror stream; also
//     bits 1,1,0,0,0,0,0,0 -> P_DATA=0xC0.
//  3. len=7, even parity, data 0x41 (two 1s), parity bit 1, stop 1 -> par_err=1,
//     data_valid=0, P_DATA unchanged. Odd type with parity bit 1 -> data_valid, P_DATA=0x41.
//  4. two_stop=1, second stop sampled 0 -> stp_err pulse only after STOP2 strobe;
//     busy high through STOP2.
//  5. deser_en dropped after 3 data bits; then a full frame 0x3C -> no pulses for the aborted
//     frame, then data_valid with P_DATA=0x3C.
//  6. Sync reset mid-DATA -> all outputs 0 next cycle; data_len=2 and data_len=15 are clamped
//     to 5 and DATA_WIDTH.

Source files
------------

// File: rtl/rx_frame_deserializer.sv
// rtl/rx_frame_deserializer.sv - UART receive deserializer with frame sequencing and checking
//
// Purpose: takes one sampled bit per sample_strobe after a confirmed start bit,
// assembles 5..DATA_WIDTH data bits LSB- or MSB-first, checks optional even/odd
// parity and one or two stop bits, and reports a registered word with a
// one-cycle data_valid pulse, or a one-cycle par_err/stp_err pulse.
//
// Ports:
//   rx_frame_deserializer_clk  clock, rising edge
//   rx_frame_deserializer_rst  synchronous active-high reset
//   deser_en                   frame enable; low aborts a frame in progress
//   start_det                  start bit confirmed (1-cycle pulse)
//   sample_strobe              bit sample point (1-cycle pulse)
//   sampled_bit                line value, valid with sample_strobe
//   data_len                   data bits per frame, clamped to 5..DATA_WIDTH
//   par_en/par_type            parity present / 0=even 1=odd
//   msb_first                  first received data bit is the MSB
//   two_stop                   two stop bits
//   P_DATA                     last good word, right-aligned
//   data_valid/par_err/stp_err one-cycle frame-end result pulses
//   busy                       high while a frame is being received

module rx_frame_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  rx_frame_deserializer_clk,
  input  logic                  rx_frame_deserializer_rst,
  input  logic                  deser_en,
  input  logic                  start_det,
  input  logic                  sample_strobe,
  input  logic                  sampled_bit,
  input  logic [LEN_W-1:0]      data_len,
  input  logic                  par_en,
  input  logic                  par_type,
  input  logic                  msb_first,
  input  logic                  two_stop,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  state_t                r_state;
  logic [LEN_W-1:0]      r_len;
  logic [LEN_W-1:0]      r_bit_cnt;
  logic                  r_par_en;
  logic                  r_par_type;
  logic                  r_msb_first;
  logic                  r_two_stop;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par;
  logic                  r_par_flag;
  logic                  r_stp_flag;

  logic [LEN_W-1:0]      w_len_clamped;
  logic [LEN_W-1:0]      w_wr_idx;
  logic                  w_last_bit;
  logic                  w_last_stop;
  logic                  w_frame_stp_err;

  always_comb begin
    w_len_clamped = data_len;
    if (data_len < LEN_W'(5)) begin
      w_len_clamped = LEN_W'(5);
    end else if (data_len > LEN_W'(DATA_WIDTH)) begin
      w_len_clamped = LEN_W'(DATA_WIDTH);
    end
  end

  // Bits are written straight to their final position so the word needs no
  // post-alignment; unused upper bits stay at their cleared value of zero.
  assign w_wr_idx        = r_msb_first ? (r_len - LEN_W'(1) - r_bit_cnt) : r_bit_cnt;
  assign w_last_bit      = (r_bit_cnt == (r_len - LEN_W'(1)));
  assign w_last_stop     = (r_state == S_STOP2) || ((r_state == S_STOP1) && !r_two_stop);
  // Includes the stop bit being sampled on the frame-end strobe itself.
  assign w_frame_stp_err = r_stp_flag | ~sampled_bit;

  always_ff @(posedge rx_frame_deserializer_clk) begin
    if (rx_frame_deserializer_rst) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_bit_cnt   <= '0;
      r_par_en    <= 1'b0;
      r_par_type  <= 1'b0;
      r_msb_first <= 1'b0;
      r_two_stop  <= 1'b0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_par_flag  <= 1'b0;
      r_stp_flag  <= 1'b0;
      P_DATA      <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;

      // Abort has priority over everything, including a frame-end strobe.
      if ((r_state != S_IDLE) && !deser_en) begin
        r_state <= S_IDLE;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start_det && deser_en) begin
              r_state     <= S_DATA;
              busy        <= 1'b1;
              r_len       <= w_len_clamped;
              r_par_en    <= par_en;
              r_par_type  <= par_type;
              r_msb_first <= msb_first;
              r_two_stop  <= two_stop;
              r_bit_cnt   <= '0;
              r_shift     <= '0;
              r_par       <= 1'b0;
              r_par_flag  <= 1'b0;
              r_stp_flag  <= 1'b0;
            end
          end

          S_DATA: begin
            if (sample_strobe) begin
              for (int i = 0; i < DATA_WIDTH; i++) begin
                if (LEN_W'(i) == w_wr_idx) begin
                  r_shift[i] <= sampled_bit;
                end
              end
              r_bit_cnt <= r_bit_cnt + LEN_W'(1);
              r_par     <= r_par ^ sampled_bit;
              if (w_last_bit) begin
                r_state <= r_par_en ? S_PARITY : S_STOP1;
              end
            end
          end

          S_PARITY: begin
            if (sample_strobe) begin
              if (sampled_bit != (r_par ^ r_par_type)) begin
                r_par_flag <= 1'b1;
              end
              r_state <= S_STOP1;
            end
          end

          S_STOP1, S_STOP2: begin
            if (sample_strobe) begin
              if (w_last_stop) begin
                r_state <= S_IDLE;
                busy    <= 1'b0;
                if (!r_par_flag && !w_frame_stp_err) begin
                  P_DATA     <= r_shift;
                  data_valid <= 1'b1;
                end else begin
                  par_err <= r_par_flag;
                  stp_err <= w_frame_stp_err;
                end
              end else begin
                r_stp_flag <= w_frame_stp_err;
                r_state    <= S_STOP2;
              end
            end
          end

          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_deserializer.sv
// tb/tb_rx_frame_deserializer.sv - self-checking bench for rx_frame_deserializer

module tb_rx_frame_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       deser_en;
  logic       start_det;
  logic       sample_strobe;
  logic       sampled_bit;
  logic [3:0] data_len;
  logic       par_en;
  logic       par_type;
  logic       msb_first;
  logic       two_stop;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 1'b0;

  // Expected outputs after the next rising edge, set by the stimulus alongside the inputs.
  logic       nxt_busy  = 1'b0;
  logic       nxt_dv    = 1'b0;
  logic       nxt_pe    = 1'b0;
  logic       nxt_se    = 1'b0;
  logic [7:0] nxt_pdata = 8'h00;

  rx_frame_deserializer #(.DATA_WIDTH(8)) dut (
    .rx_frame_deserializer_clk(clk),
    .rx_frame_deserializer_rst(rst),
    .deser_en(deser_en),
    .start_det(start_det),
    .sample_strobe(sample_strobe),
    .sampled_bit(sampled_bit),
    .data_len(data_len),
    .par_en(par_en),
    .par_type(par_type),
    .msb_first(msb_first),
    .two_stop(two_stop),
    .P_DATA(P_DATA),
    .data_valid(data_valid),
    .par_err(par_err),
    .stp_err(stp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Compare process: latch expectations at the edge, compare on the falling edge.
  initial begin
    logic       e_busy, e_dv, e_pe, e_se;
    logic [7:0] e_pdata;
    forever begin
      @(posedge clk);
      e_busy  = nxt_busy;
      e_dv    = nxt_dv;
      e_pe    = nxt_pe;
      e_se    = nxt_se;
      e_pdata = nxt_pdata;
      @(negedge clk);
      if (!done) begin
        chk("busy", busy, e_busy);
        chk("data_valid", data_valid, e_dv);
        chk("par_err", par_err, e_pe);
        chk("stp_err", stp_err, e_se);
        chk("P_DATA", P_DATA, e_pdata);
      end
    end
  end

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    start_det     = 1'b0;
    sample_strobe = 1'b0;
    sampled_bit   = 1'($urandom);
    nxt_dv        = 1'b0;
    nxt_pe        = 1'b0;
    nxt_se        = 1'b0;
  endtask

  task automatic gap(input int maxn);
    int n;
    n = $urandom_range(0, maxn);
    repeat (n) begin
      start_det = ($urandom % 4 == 0);
      cyc();
    end
  endtask

  // tx[k] is the k-th transmitted data bit. abort_at >= 0 drops deser_en before data bit abort_at.
  task automatic send_frame(input logic [3:0] raw_len, input logic [7:0] tx,
                            input logic pe, input logic pt, input logic msb, input logic ts,
                            input logic par_bad, input logic [1:0] stop_bad, input int abort_at);
    int         len;
    int         word;
    int         nstop;
    logic       err_p, err_s;
    len = (raw_len < 5) ? 5 : ((raw_len > 8) ? 8 : int'(raw_len));
    if (msb) begin
      word = 0;
      for (int k = 0; k < len; k++) word = word * 2 + int'(tx[k]);
    end else begin
      word = int'(tx) % (1 << len);
    end
    // Idle cycles with stray strobes, which must be ignored.
    repeat ($urandom_range(0, 2)) begin
      sample_strobe = 1'($urandom);
      cyc();
    end
    start_det     = 1'b1;
    sample_strobe = 1'($urandom);
    data_len      = raw_len;
    par_en        = pe;
    par_type      = pt;
    msb_first     = msb;
    two_stop      = ts;
    nxt_busy      = 1'b1;
    cyc();
    // Configuration is captured at start; scrambling it afterwards must have no effect.
    data_len  = 4'($urandom);
    par_en    = 1'($urandom);
    par_type  = 1'($urandom);
    msb_first = 1'($urandom);
    two_stop  = 1'($urandom);
    for (int k = 0; k < len; k++) begin
      gap(2);
      if (k == abort_at) begin
        deser_en = 1'b0;
        nxt_busy = 1'b0;
        cyc();
        deser_en = 1'b1;
        return;
      end
      sample_strobe = 1'b1;
      sampled_bit   = tx[k];
      cyc();
    end
    if (pe) begin
      gap(2);
      sample_strobe = 1'b1;
      sampled_bit   = (^word[7:0]) ^ pt ^ par_bad;
      cyc();
    end
    nstop = ts ? 2 : 1;
    err_p = pe & par_bad;
    err_s = stop_bad[0] | (ts & stop_bad[1]);
    for (int s = 0; s < nstop; s++) begin
      gap(2);
      sample_strobe = 1'b1;
      sampled_bit   = ~stop_bad[s];
      if (s == nstop - 1) begin
        nxt_busy = 1'b0;
        if (!err_p && !err_s) begin
          nxt_dv    = 1'b1;
          nxt_pdata = word[7:0];
        end else begin
          nxt_pe = err_p;
          nxt_se = err_s;
        end
      end
      cyc();
    end
  endtask

  initial begin
    rst           = 1'b1;
    deser_en      = 1'b1;
    start_det     = 1'b0;
    sample_strobe = 1'b0;
    sampled_bit   = 1'b1;
    data_len      = 4'd8;
    par_en        = 1'b0;
    par_type      = 1'b0;
    msb_first     = 1'b0;
    two_stop      = 1'b0;
    cyc();
    cyc();
    chk("reset_pdata", P_DATA, 8'h00);
    chk("reset_busy", busy, 1'b0);
    rst = 1'b0;
    cyc();

    // Bits 1,0,1,0,0,1,0,1 LSB-first.
    send_frame(4'd8, 8'hA5, 0, 0, 0, 0, 0, 2'b00, -1);
    chk("t1_dv", data_valid, 1'b1);
    chk("t1_pdata", P_DATA, 8'hA5);
    cyc();
    chk("t1_dv_one_cycle", data_valid, 1'b0);

    send_frame(4'd8, 8'hA5, 0, 0, 1, 0, 0, 2'b00, -1);
    chk("t2a_pdata", P_DATA, 8'hA5);
    // Bits 1,1,0,0,0,0,0,0 MSB-first.
    send_frame(4'd8, 8'h03, 0, 0, 1, 0, 0, 2'b00, -1);
    chk("t2b_pdata", P_DATA, 8'hC0);

    // 0x41 even parity with parity bit 1.
    send_frame(4'd7, 8'h41, 1, 0, 0, 0, 1, 2'b00, -1);
    chk("t3a_par_err", par_err, 1'b1);
    chk("t3a_dv", data_valid, 1'b0);
    chk("t3a_pdata", P_DATA, 8'hC0);
    send_frame(4'd7, 8'h41, 1, 1, 0, 0, 0, 2'b00, -1);
    chk("t3b_dv", data_valid, 1'b1);
    chk("t3b_pdata", P_DATA, 8'h41);

    send_frame(4'd8, 8'h5A, 0, 0, 0, 1, 0, 2'b10, -1);
    chk("t4_stp_err", stp_err, 1'b1);
    chk("t4_par_err", par_err, 1'b0);
    chk("t4_dv", data_valid, 1'b0);
    chk("t4_pdata", P_DATA, 8'h41);

    send_frame(4'd8, 8'hFF, 0, 0, 0, 0, 0, 2'b00, 3);
    chk("t5_abort_busy", busy, 1'b0);
    chk("t5_abort_pdata", P_DATA, 8'h41);
    send_frame(4'd8, 8'h3C, 0, 0, 0, 0, 0, 2'b00, -1);
    chk("t5_pdata", P_DATA, 8'h3C);

    // Reset in the middle of the data bits.
    start_det = 1'b1;
    data_len  = 4'd8;
    nxt_busy  = 1'b1;
    cyc();
    repeat (2) begin
      sample_strobe = 1'b1;
      cyc();
    end
    rst       = 1'b1;
    nxt_busy  = 1'b0;
    nxt_pdata = 8'h00;
    cyc();
    rst = 1'b0;
    chk("t6_rst_pdata", P_DATA, 8'h00);
    chk("t6_rst_busy", busy, 1'b0);
    cyc();
    send_frame(4'd2, 8'hF6, 0, 0, 0, 0, 0, 2'b00, -1);
    chk("t6_len2_pdata", P_DATA, 8'h16);
    send_frame(4'd15, 8'h9B, 0, 0, 0, 0, 0, 2'b00, -1);
    chk("t6_len15_pdata", P_DATA, 8'h9B);

    for (int f = 0; f < 150; f++) begin
      send_frame(4'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), ($urandom % 5 == 0), {($urandom % 6 == 0), ($urandom % 6 == 0)},
                 ($urandom % 8 == 0) ? int'($urandom_range(0, 4)) : -1);
    end
    cyc();
    cyc();
    @(negedge clk);
    #1;
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
